// File: rtl/ram_stream_ctrl.sv
// Burst controller between a single-port synchronous RAM and a pair of
// valid/ready streams: write bursts sink s_data, read bursts source m_data.
module ram_stream_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [AW:0]      cmd_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             ram_write_en,
    output logic             ram_read_en,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    addr;
    logic [AW:0]      issue_left;
    logic [AW:0]      out_left;
    logic [WIDTH-1:0] fifo_mem [2];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       fifo_cnt;
    logic             in_flight;
    logic             done_r, done_nxt;
    logic             accept, beat, pop;
    logic [2:0]       occupancy;

    assign accept    = cmd_valid && cmd_ready;
    assign beat      = s_valid && s_ready;
    assign pop       = m_valid && m_ready;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign s_ready   = (state == WR);
    assign done      = done_r;

    assign m_valid   = (fifo_cnt != 2'd0);
    assign m_data    = fifo_mem[rd_ptr];
    assign m_last    = m_valid && (out_left == (AW+1)'(1));

    // Words that will occupy the output buffer next cycle if no new read is issued.
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, in_flight} - {2'b00, pop};

    assign ram_write_en = beat;
    assign ram_read_en  = (state == RD) && (issue_left != '0) && (occupancy < 3'd2);
    assign ram_addr     = (state != IDLE) ? addr : '0;
    assign ram_data_in  = (state == WR) ? s_data : '0;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = cmd_write ? WR : RD;
                    end
                end
            end
            WR: begin
                if (beat && issue_left == (AW+1)'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            RD: begin
                if (pop && out_left == (AW+1)'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            done_r     <= 1'b0;
            addr       <= '0;
            issue_left <= '0;
            out_left   <= '0;
            in_flight  <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_r    <= done_nxt;
            in_flight <= ram_read_en;
            if (accept) begin
                addr       <= cmd_addr;
                issue_left <= cmd_len;
                out_left   <= cmd_len;
            end else begin
                if (ram_write_en || ram_read_en) begin
                    addr       <= (addr == AW'(DEPTH-1)) ? '0 : addr + 1'b1;
                    issue_left <= issue_left - 1'b1;
                end
                if (pop) begin
                    out_left <= out_left - 1'b1;
                end
            end
        end
    end

    // RAM data arrives one cycle after its read strobe and is pushed into the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (in_flight) begin
                fifo_mem[wr_ptr] <= ram_data_out;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, in_flight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Directed self-checking bench for ram_stream_ctrl with a behavioural
// synchronous single-port RAM attached.
module tb_ram_stream_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic             clk;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]    cmd_addr;
    logic [AW:0]      cmd_len;
    logic             s_valid, s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid, m_ready, m_last;
    logic [WIDTH-1:0] m_data;
    logic             busy, done;
    logic             ram_write_en, ram_read_en;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_data_in, ram_data_out;

    logic [WIDTH-1:0] ram_mem [DEPTH];

    int n_cmp;
    int n_err;

    ram_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done),
        .ram_write_en (ram_write_en),
        .ram_read_en  (ram_read_en),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after ram_read_en.
    always @(posedge clk) begin
        if (ram_write_en) ram_mem[ram_addr] <= ram_data_in;
        if (ram_read_en)  ram_data_out <= ram_mem[ram_addr];
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Presents one command for a single cycle; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic wr, input int addr, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr[AW-1:0];
        cmd_len   = len[AW:0];
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic writeBurst(input int addr, input int len, input int base);
        applyStimulus(1'b1, addr, len);
        for (int i = 0; i < len; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(base + i);
            #1;
            checkOutput("wr_busy",  {31'd0, busy}, 1);
            checkOutput("wr_cmd_ready", {31'd0, cmd_ready}, 0);
            checkOutput("wr_en",    {31'd0, ram_write_en}, 1);
            checkOutput("wr_excl",  {31'd0, ram_read_en}, 0);
            checkOutput("wr_addr",  {22'd0, ram_addr}, (addr + i) % DEPTH);
            checkOutput("wr_data",  {16'd0, ram_data_in}, (base + i) & 16'hFFFF);
            @(negedge clk);
        end
        s_valid = 1'b0;
        #1;
        checkOutput("wr_done",      {31'd0, done}, 1);
        checkOutput("wr_end_busy",  {31'd0, busy}, 0);
        checkOutput("wr_end_en",    {31'd0, ram_write_en}, 0);
        @(negedge clk);
        checkOutput("wr_done_pulse", {31'd0, done}, 0);
    endtask

    task automatic readBurst(input int addr, input int len, input int base, input logic stall);
        logic [3:0]       pat;
        logic             prev_stall;
        logic [WIDTH-1:0] prev_data;
        int               got, issued, popped, first, k;
        pat        = 4'b1001;
        prev_stall = 1'b0;
        prev_data  = '0;
        got = 0; issued = 0; popped = 0; first = -1; k = 0;
        applyStimulus(1'b0, addr, len);
        #1;
        checkOutput("rd_first_en",   {31'd0, ram_read_en}, 1);
        checkOutput("rd_first_addr", {22'd0, ram_addr}, addr % DEPTH);
        while (got < len && k < 60) begin
            m_ready = stall ? pat[k % 4] : 1'b1;
            #1;
            if (prev_stall) begin
                checkOutput("stall_valid", {31'd0, m_valid}, 1);
                checkOutput("stall_data",  {16'd0, m_data}, {16'd0, prev_data});
            end
            if (m_valid && first < 0) first = k;
            if (ram_read_en) begin
                issued++;
                checkOutput("rd_excl", {31'd0, ram_write_en}, 0);
            end
            if (m_valid && m_ready) begin
                checkOutput("rd_data", {16'd0, m_data}, (base + got) & 16'hFFFF);
                checkOutput("rd_last", {31'd0, m_last}, (got == len - 1) ? 1 : 0);
                got++;
                popped++;
            end
            checkOutput("rd_outstanding", (issued - popped) <= 2 ? 1 : 0, 1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            k++;
            @(negedge clk);
        end
        checkOutput("rd_latency",  first, 2);
        checkOutput("rd_complete", got, len);
        m_ready = 1'b0;
        #1;
        checkOutput("rd_done",     {31'd0, done}, 1);
        checkOutput("rd_end_valid", {31'd0, m_valid}, 0);
        checkOutput("rd_end_busy", {31'd0, busy}, 0);
        @(negedge clk);
        checkOutput("rd_done_pulse", {31'd0, done}, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        checkOutput("rst_busy",      {31'd0, busy}, 0);
        checkOutput("rst_done",      {31'd0, done}, 0);
        checkOutput("rst_s_ready",   {31'd0, s_ready}, 0);
        checkOutput("rst_m_valid",   {31'd0, m_valid}, 0);
        checkOutput("rst_m_last",    {31'd0, m_last}, 0);
        checkOutput("rst_m_data",    {16'd0, m_data}, 0);
        checkOutput("rst_wr_en",     {31'd0, ram_write_en}, 0);
        checkOutput("rst_rd_en",     {31'd0, ram_read_en}, 0);
        checkOutput("rst_addr",      {22'd0, ram_addr}, 0);
        rst = 1'b0;

        $display("[TB] write 0x010 len 4");
        writeBurst(16'h010, 4, 16'h00A0);
        $display("[TB] read 0x010 len 4, m_ready high");
        readBurst(16'h010, 4, 16'h00A0, 1'b0);
        $display("[TB] read 0x010 len 4, m_ready toggling");
        readBurst(16'h010, 4, 16'h00A0, 1'b1);
        $display("[TB] write wrap 0x3FE len 4");
        writeBurst(16'h3FE, 4, 16'h00B0);
        readBurst(16'h3FE, 4, 16'h00B0, 1'b1);

        $display("[TB] zero-length command");
        applyStimulus(1'b1, 16'h020, 0);
        #1;
        checkOutput("len0_done",      {31'd0, done}, 1);
        checkOutput("len0_cmd_ready", {31'd0, cmd_ready}, 1);
        checkOutput("len0_busy",      {31'd0, busy}, 0);
        checkOutput("len0_s_ready",   {31'd0, s_ready}, 0);
        checkOutput("len0_wr_en",     {31'd0, ram_write_en}, 0);
        checkOutput("len0_rd_en",     {31'd0, ram_read_en}, 0);
        @(negedge clk);
        checkOutput("len0_done_pulse", {31'd0, done}, 0);

        $display("[TB] reset mid-read");
        m_ready = 1'b1;
        applyStimulus(1'b0, 16'h010, 4);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("pre_rst_valid", {31'd0, m_valid}, 1);
        checkOutput("pre_rst_data",  {16'd0, m_data}, 16'h00A2);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid",     {31'd0, m_valid}, 0);
        checkOutput("mid_rst_busy",      {31'd0, busy}, 0);
        checkOutput("mid_rst_cmd_ready", {31'd0, cmd_ready}, 1);
        checkOutput("mid_rst_rd_en",     {31'd0, ram_read_en}, 0);
        checkOutput("mid_rst_addr",      {22'd0, ram_addr}, 0);
        checkOutput("mid_rst_m_data",    {16'd0, m_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("post_rst_no_done", {31'd0, done}, 0);
            checkOutput("post_rst_valid",   {31'd0, m_valid}, 0);
            @(negedge clk);
        end
        readBurst(16'h010, 4, 16'h00A0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_stream_ctrl.md
RAM_STREAM_CTRL -- requirements
Module: ram_stream_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 1024, RAM word count; AW = $clog2(DEPTH).
REQ-003 The block SHALL have one clock and an asynchronous active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-006 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr  in  AW  burst base address.
REQ-008 cmd_len  in  AW+1  burst length in words (0..DEPTH).
REQ-009 s_valid / s_ready / s_data  in / out / in  1 / 1 / WIDTH  write-data stream.
REQ-010 m_valid / m_ready / m_data / m_last  out / in / out / out  1 / 1 / WIDTH / 1  read-data stream.
REQ-011 busy / done  out / out  1 / 1  burst active; one-cycle completion pulse.
REQ-012 ram_write_en / ram_read_en / ram_addr / ram_data_in  out  1 / 1 / AW / WIDTH  to single-port RAM.
REQ-013 ram_data_out  in  WIDTH  RAM read data, valid the cycle after ram_read_en.

Function
REQ-014 FSM states SHALL be IDLE, WR, RD; cmd_ready = 1 only in IDLE; busy = (state != IDLE).
REQ-015 Command accepted on the edge where cmd_valid && cmd_ready; base address and length are latched; cmd_len = 0 SHALL return to IDLE with done pulsed the next cycle and no RAM access.
REQ-016 WR: s_ready = 1; on each s_valid && s_ready, in the same cycle, ram_write_en = 1, ram_addr = current address, ram_data_in = s_data (combinational).
REQ-017 RD: ram_read_en = 1 when reads remain and (buffered words + reads in flight - pop this cycle) < 2; ram_addr = current read address.
REQ-018 Read data SHALL be captured from ram_data_out on the edge after ram_read_en into a 2-entry output FIFO; m_data/m_valid come from the FIFO head (registered).
REQ-019 Read latency: first m_valid SHALL be asserted 2 cycles after the command-accept edge; with m_ready held at 1, one word per cycle thereafter.
REQ-020 m_valid/m_data SHALL hold stable while m_valid && !m_ready; the RAM SHALL NOT be read when the buffer has no room.
REQ-021 m_last = 1 on the final word of a read burst.
REQ-022 Address SHALL increment by 1 per access and wrap from DEPTH-1 to 0.
REQ-023 WR ends on the edge accepting the last beat; RD ends on the edge of the last m_valid && m_ready; both go to IDLE with done = 1 for exactly the next cycle.
REQ-024 ram_write_en and ram_read_en SHALL never be asserted in the same cycle; both are 0 in IDLE.
REQ-025 s_ready = 0 outside WR; s_data is ignored outside WR.

Reset
REQ-026 While rst = 1: state IDLE; output FIFO empty; counters zero; cmd_ready = 1; s_ready, m_valid, m_last, busy, done, ram_write_en, ram_read_en = 0; ram_addr = 0; m_data = 0.
REQ-027 Reset mid-burst SHALL abort the burst immediately, discard buffered and in-flight read data, and raise no done pulse.

Verification
REQ-028 Write cmd addr=0x010 len=4, s_data 0xA0..0xA3 back-to-back -> 4 consecutive ram_write_en cycles at 0x010..0x013, done one cycle after the last beat.
REQ-029 Read cmd addr=0x010 len=4, m_ready = 1 -> m_valid 2 cycles after accept, m_data 0xA0..0xA3 on consecutive cycles, m_last on 0xA3, then done.
REQ-030 Same read with m_ready toggling 1,0,0,1,... -> no lost or duplicated words, m_data stable while stalled, at most 2 reads outstanding.
REQ-031 Write addr=0x3FE len=4 -> writes hit 0x3FE, 0x3FF, 0x000, 0x001.
REQ-032 cmd_len = 0 -> no RAM enables, done one cycle after accept, cmd_ready = 1 next cycle.
REQ-033 rst asserted after 2 of 4 read words are delivered -> m_valid = 0 immediately, no done pulse, cmd_ready = 1, and a following command runs normally.
